// File: rtl/game_pkg.sv
// Shared encodings for the two-board link: control_unit states, link byte fields and TX FSM states.
package game_pkg;

    typedef enum logic [2:0] {
        ST_MENU       = 3'b000,
        ST_GAME       = 3'b001,
        ST_VICTORY    = 3'b010,
        ST_GAME_OVER  = 3'b011,
        ST_MULTI_WAIT = 3'b100
    } game_state_t;

    localparam logic [1:0] MSG_MARKER = 2'b10;

    typedef enum logic [2:0] {
        MSG_BEACON = 3'b000,
        MSG_READY  = 3'b001,
        MSG_LOST   = 3'b010,
        MSG_ACK    = 3'b011
    } msg_type_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_SEND  = 2'b01,
        TX_GUARD = 2'b10,
        TX_WAIT  = 2'b11
    } tx_state_t;

    function automatic logic [7:0] make_msg(input msg_type_t kind, input logic [2:0] sender);
        return {MSG_MARKER, kind, sender};
    endfunction

    // Known types all have bit 5 clear; anything else is noise on the wire.
    function automatic logic msg_ok(input logic [7:0] b);
        return (b[7:6] == MSG_MARKER) && (b[5] == 1'b0);
    endfunction

endpackage

// File: rtl/beacon_timer.sv
// Free-running beacon period counter; emits a one-cycle tick every BEACON_CYCLES clocks while enabled.
module beacon_timer #(
    parameter int BEACON_CYCLES = 6_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = (BEACON_CYCLES > 1) ? $clog2(BEACON_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // Period counter, held at zero while the link is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(BEACON_CYCLES - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_link_ctrl.sv
// Link scheduler: arbitrates the UART transmitter between ACK/LOST/READY/BEACON messages
// and decodes received bytes into opponent status and link health.
module multi_link_ctrl
    import game_pkg::*;
#(
    parameter int BEACON_CYCLES   = 6_500_000,
    parameter int TIMEOUT_BEACONS = 5,
    parameter int MAX_RETRY       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       multiplayer,
    input  logic       player_ready,
    input  logic       game_over,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       opponent_ready,
    output logic       opponent_lost,
    output logic       link_up,
    output logic       link_timeout
);
    localparam int MW = $clog2(TIMEOUT_BEACONS + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    tx_state_t     tx_state, tx_next;
    logic          tick;
    logic          player_ready_d, game_over_d;
    logic          ready_rise, lost_event;
    logic          rx_ok, rx_lost, rx_ack;
    logic          beacon_pend, ready_pend, lost_pend, ack_pend, lost_active;
    logic [RW-1:0] retry_cnt;
    logic          grant, grant_ack, grant_lost, grant_ready, grant_beacon;
    logic [7:0]    tx_byte;
    logic [MW-1:0] miss_cnt, miss_n;
    logic [2:0]    last_state, last_n;
    logic          link_n, timeout_n, lost_seen;

    beacon_timer #(.BEACON_CYCLES(BEACON_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (multiplayer),
        .tick (tick)
    );

    assign ready_rise = player_ready & ~player_ready_d;
    assign lost_event = game_over & ~game_over_d & (state == ST_GAME);
    assign rx_ok      = rx_valid & msg_ok(rx_data);
    assign rx_lost    = rx_ok & (rx_data[5:3] == MSG_LOST);
    assign rx_ack     = rx_ok & (rx_data[5:3] == MSG_ACK);
    assign grant      = (tx_state == TX_IDLE) && (tx_next == TX_SEND);

    // Edge detectors for the local events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            player_ready_d <= 1'b0;
            game_over_d    <= 1'b0;
        end else begin
            player_ready_d <= player_ready;
            game_over_d    <= game_over;
        end
    end

    // TX next-state and priority arbitration ACK > LOST > READY > BEACON
    always_comb begin
        tx_next      = tx_state;
        tx_byte      = 8'h00;
        grant_ack    = 1'b0;
        grant_lost   = 1'b0;
        grant_ready  = 1'b0;
        grant_beacon = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (multiplayer && !tx_busy && (ack_pend || lost_pend || ready_pend || beacon_pend)) begin
                    tx_next = TX_SEND;
                    if (ack_pend) begin
                        grant_ack = 1'b1;
                        tx_byte   = make_msg(MSG_ACK, state);
                    end else if (lost_pend) begin
                        grant_lost = 1'b1;
                        tx_byte    = make_msg(MSG_LOST, state);
                    end else if (ready_pend) begin
                        grant_ready = 1'b1;
                        tx_byte     = make_msg(MSG_READY, state);
                    end else begin
                        grant_beacon = 1'b1;
                        tx_byte      = make_msg(MSG_BEACON, state);
                    end
                end else begin
                    tx_next = TX_IDLE;
                end
            end
            TX_SEND:  tx_next = TX_GUARD;
            TX_GUARD: tx_next = TX_WAIT;
            TX_WAIT: begin
                if (!tx_busy) begin
                    tx_next = TX_IDLE;
                end else begin
                    tx_next = TX_WAIT;
                end
            end
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX FSM register; the byte is latched at grant and held through the send
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_state <= tx_next;
            tx_start <= (tx_next == TX_SEND);
            if (grant) begin
                tx_data <= tx_byte;
            end
        end
    end

    // Pending flags and LOST retry bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beacon_pend <= 1'b0;
            ready_pend  <= 1'b0;
            ack_pend    <= 1'b0;
            lost_pend   <= 1'b0;
            lost_active <= 1'b0;
            retry_cnt   <= '0;
        end else if (!multiplayer) begin
            beacon_pend <= 1'b0;
            ready_pend  <= 1'b0;
            ack_pend    <= 1'b0;
            lost_pend   <= 1'b0;
            lost_active <= 1'b0;
            retry_cnt   <= '0;
        end else begin
            beacon_pend <= tick | (beacon_pend & ~grant_beacon);
            ready_pend  <= ready_rise | (ready_pend & ~grant_ready);
            ack_pend    <= rx_lost | (ack_pend & ~grant_ack);
            if (lost_event) begin
                lost_pend   <= 1'b1;
                lost_active <= 1'b1;
                retry_cnt   <= '0;
            end else if (rx_ack) begin
                lost_pend   <= 1'b0;
                lost_active <= 1'b0;
                retry_cnt   <= '0;
            end else if (grant_lost) begin
                lost_pend <= 1'b0;
                if (retry_cnt != RW'(MAX_RETRY)) begin
                    retry_cnt <= retry_cnt + RW'(1);
                end
            end else if (tick && lost_active && (retry_cnt < RW'(MAX_RETRY))) begin
                lost_pend <= 1'b1;
            end
        end
    end

    // Link health: a valid byte always beats a same-cycle tick
    always_comb begin
        link_n    = link_up;
        miss_n    = miss_cnt;
        last_n    = last_state;
        timeout_n = 1'b0;
        if (rx_ok) begin
            link_n = 1'b1;
            miss_n = '0;
            last_n = rx_data[2:0];
        end else if (tick) begin
            if (miss_cnt != MW'(TIMEOUT_BEACONS)) begin
                miss_n = miss_cnt + MW'(1);
            end else begin
                miss_n = miss_cnt;
            end
            if (link_up && (miss_n == MW'(TIMEOUT_BEACONS))) begin
                link_n    = 1'b0;
                timeout_n = 1'b1;
            end else begin
                link_n = link_up;
            end
        end else begin
            link_n = link_up;
        end
    end

    // Registered RX view and opponent status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_up        <= 1'b0;
            miss_cnt       <= '0;
            last_state     <= 3'b000;
            link_timeout   <= 1'b0;
            opponent_ready <= 1'b0;
            opponent_lost  <= 1'b0;
            lost_seen      <= 1'b0;
        end else if (!multiplayer) begin
            link_up        <= 1'b0;
            miss_cnt       <= '0;
            last_state     <= 3'b000;
            link_timeout   <= 1'b0;
            opponent_ready <= 1'b0;
            opponent_lost  <= 1'b0;
            lost_seen      <= 1'b0;
        end else begin
            link_up        <= link_n;
            miss_cnt       <= miss_n;
            last_state     <= last_n;
            link_timeout   <= timeout_n;
            opponent_ready <= link_n && ((last_n == ST_GAME) || (last_n == ST_MULTI_WAIT));
            opponent_lost  <= rx_lost && !lost_seen;
            if (state != ST_GAME) begin
                lost_seen <= 1'b0;
            end else if (rx_lost) begin
                lost_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_link_ctrl.sv
// Scoreboard bench for multi_link_ctrl: expected TX bytes are queued as stimulus is applied
// and compared in order as the DUT strobes tx_start.
module tb_multi_link_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state = 3'b000;
    logic       multiplayer = 1'b0;
    logic       player_ready = 1'b0;
    logic       game_over = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start, opponent_ready, opponent_lost, link_up, link_timeout;

    int n_tests = 0, n_fail = 0;
    int extra_tx = 0, lost_pulses = 0, timeout_pulses = 0;
    int busy_cnt = 0, cyc = 0, last_tx_cyc = 0;
    int t1, t2;
    logic [7:0] exp_q[$];

    multi_link_ctrl #(.BEACON_CYCLES(100), .TIMEOUT_BEACONS(5), .MAX_RETRY(4)) dut (
        .clk(clk), .rst(rst), .state(state), .multiplayer(multiplayer),
        .player_ready(player_ready), .game_over(game_over),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .opponent_ready(opponent_ready), .opponent_lost(opponent_lost),
        .link_up(link_up), .link_timeout(link_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART model: busy for 10 cycles after each start strobe
    always @(negedge clk) begin
        if (tx_start) busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        tx_busy = (busy_cnt != 0);
    end

    always @(negedge clk) begin
        if (!rst && tx_start) begin
            last_tx_cyc = cyc;
            if (exp_q.size() > 0) check_val("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            else extra_tx++;
        end
        if (!rst && opponent_lost) lost_pulses++;
        if (!rst && link_timeout) timeout_pulses++;
    end

    task automatic wait_empty(input string tag, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        check_val(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    initial begin
        repeat (3) @(posedge clk); #1;
        check_val("rst_tx_start", 32'(tx_start), 32'd0);
        check_val("rst_tx_data", 32'(tx_data), 32'd0);
        check_val("rst_opp_ready", 32'(opponent_ready), 32'd0);
        check_val("rst_opp_lost", 32'(opponent_lost), 32'd0);
        check_val("rst_link_up", 32'(link_up), 32'd0);
        check_val("rst_link_timeout", 32'(link_timeout), 32'd0);
        rst = 1'b0;

        // Idle beacons in MENU every 100 cycles
        state = 3'b000; multiplayer = 1'b1;
        exp_q.push_back(8'h80); wait_empty("beacon1", 150); t1 = last_tx_cyc;
        exp_q.push_back(8'h80); wait_empty("beacon2", 150); t2 = last_tx_cyc;
        check_val("beacon_period_a", 32'(t2 - t1), 32'd100);
        t1 = t2;
        exp_q.push_back(8'h80); wait_empty("beacon3", 150); t2 = last_tx_cyc;
        check_val("beacon_period_b", 32'(t2 - t1), 32'd100);

        // Local loss with no ACK: four LOST bytes, one per tick, then beacons only
        state = 3'b001;
        repeat (20) @(posedge clk); #1;
        exp_q.push_back(8'h91);
        game_over = 1'b1;
        @(posedge clk); #1;
        check_val("lost_lat_n1", 32'(tx_start), 32'd0);
        @(posedge clk); #1;
        check_val("lost_lat_n2", 32'(tx_start), 32'd1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h91);
            exp_q.push_back(8'h81);
        end
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h81);
        wait_empty("lost_retry", 700);
        multiplayer = 1'b0; game_over = 1'b0;
        repeat (20) @(posedge clk);

        // Opponent LOST twice: one pulse, two ACKs; ACK ahead of a same-cycle beacon
        multiplayer = 1'b1;
        repeat (8) @(posedge clk);
        exp_q.push_back(8'h99);
        send_rx(8'h91);
        check_val("opp_lost_pulse", 32'(opponent_lost), 32'd1);
        check_val("opp_lost_link", 32'(link_up), 32'd1);
        check_val("opp_lost_ready", 32'(opponent_ready), 32'd1);
        @(posedge clk); #1;
        check_val("opp_lost_1cyc", 32'(opponent_lost), 32'd0);
        wait_empty("ack1", 50);
        exp_q.push_back(8'h81); wait_empty("beacon_game", 150);
        repeat (97) @(posedge clk);
        exp_q.push_back(8'h99);
        exp_q.push_back(8'h81);
        send_rx(8'h91);
        check_val("opp_lost_repeat", 32'(opponent_lost), 32'd0);
        wait_empty("ack_vs_beacon", 50);
        check_val("opp_lost_count", 32'(lost_pulses), 32'd1);
        multiplayer = 1'b0;
        repeat (20) @(posedge clk);

        // Opponent in MULTI_WAIT then silence until timeout
        state = 3'b000; multiplayer = 1'b1;
        repeat (3) @(posedge clk);
        send_rx(8'h84);
        check_val("wait_link_up", 32'(link_up), 32'd1);
        check_val("wait_opp_ready", 32'(opponent_ready), 32'd1);
        player_ready = 1'b1;
        exp_q.push_back(8'h88); wait_empty("ready_send", 20);
        player_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h80); wait_empty("timeout_beacon", 150);
            check_val("timeout_link_up", 32'(link_up), (i < 4) ? 32'd1 : 32'd0);
        end
        check_val("timeout_opp_ready", 32'(opponent_ready), 32'd0);
        repeat (5) @(posedge clk);
        check_val("timeout_pulses", 32'(timeout_pulses), 32'd1);

        // Malformed bytes while link is down change nothing
        send_rx(8'h11);
        check_val("bad_marker_link", 32'(link_up), 32'd0);
        check_val("bad_marker_ready", 32'(opponent_ready), 32'd0);
        check_val("bad_marker_lost", 32'(opponent_lost), 32'd0);
        check_val("bad_marker_tmo", 32'(link_timeout), 32'd0);
        send_rx(8'hA0);
        check_val("bad_type_link", 32'(link_up), 32'd0);
        multiplayer = 1'b0;
        repeat (20) @(posedge clk);

        // Reset while waiting on a busy UART
        multiplayer = 1'b1;
        exp_q.push_back(8'h80); wait_empty("pre_rst_beacon", 150);
        repeat (4) @(posedge clk); #1;
        rst = 1'b1; #1;
        check_val("midrst_tx_start", 32'(tx_start), 32'd0);
        check_val("midrst_tx_data", 32'(tx_data), 32'd0);
        check_val("midrst_link_up", 32'(link_up), 32'd0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(8'h80); wait_empty("post_rst_beacon", 150);

        check_val("extra_tx", 32'(extra_tx), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
